// File: rtl/shift_sub_divider_pkg.sv
// Shared types and defaults for the shift/subtract divider.
package shift_sub_div_pkg;

  localparam int DIV_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/shift_sub_divider_if.sv
// Operand and result handshakes of the divider; master drives operands, slave is the divider.
import shift_sub_div_pkg::*;

interface shift_sub_divider_if #(
  parameter int N = DIV_W
);

  logic         start_valid;
  logic         start_ready;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         result_valid;
  logic         result_ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
  logic         busy;

  modport master (
    output start_valid, dividend, divisor, result_ready,
    input  start_ready, result_valid, quotient, remainder, div_by_zero, busy
  );

  modport slave (
    input  start_valid, dividend, divisor, result_ready,
    output start_ready, result_valid, quotient, remainder, div_by_zero, busy
  );

endinterface

// File: rtl/shift_sub_divider_div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract D, set the new quotient bit.
module div_step #(
  parameter int N = 8
) (
  input  logic [N:0]   r_i,
  input  logic [N-1:0] q_i,
  input  logic [N-1:0] d_i,
  output logic [N:0]   r_o,
  output logic [N-1:0] q_o
);

  logic [N+1:0] r_shift;
  logic [N+1:0] trial;
  logic         neg;

  // One extra bit of headroom keeps the borrow visible in trial[N+1].
  assign r_shift = {r_i, q_i[N-1]};
  assign trial   = r_shift - {2'b00, d_i};
  assign neg     = trial[N+1];

  assign r_o = neg ? r_shift[N:0] : trial[N:0];
  assign q_o = {q_i[N-2:0], ~neg};

endmodule

// File: rtl/shift_sub_divider.sv
// Multi-cycle unsigned divider: one quotient bit per clock, valid/ready on both operand and result sides.
import shift_sub_div_pkg::*;

module shift_sub_divider #(
  parameter int N = DIV_W
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_sub_divider_if.slave    bus
);

  localparam int CW = $clog2(N);

  div_state_t   state_q;
  logic [N:0]   r_q;
  logic [N-1:0] q_q;
  logic [N-1:0] d_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0] quotient_q;
  logic [N-1:0] remainder_q;
  logic         dbz_q;
  logic         start_ready_q;
  logic         result_valid_q;
  logic         busy_q;

  logic [N:0]   r_d;
  logic [N-1:0] q_d;

  div_step #(.N(N)) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (r_d),
    .q_o (q_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      r_q            <= '0;
      q_q            <= '0;
      d_q            <= '0;
      cnt_q          <= '0;
      quotient_q     <= '0;
      remainder_q    <= '0;
      dbz_q          <= 1'b0;
      start_ready_q  <= 1'b1;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_valid) begin
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            if (bus.divisor == '0) begin
              quotient_q     <= '1;
              remainder_q    <= bus.dividend;
              dbz_q          <= 1'b1;
              result_valid_q <= 1'b1;
              state_q        <= DONE;
            end else begin
              r_q     <= '0;
              q_q     <= bus.dividend;
              d_q     <= bus.divisor;
              cnt_q   <= CW'(N - 1);
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            quotient_q     <= q_d;
            remainder_q    <= r_d[N-1:0];
            dbz_q          <= 1'b0;
            result_valid_q <= 1'b1;
            state_q        <= DONE;
          end
        end
        DONE: begin
          if (bus.result_ready) begin
            result_valid_q <= 1'b0;
            start_ready_q  <= 1'b1;
            busy_q         <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: begin
          result_valid_q <= 1'b0;
          start_ready_q  <= 1'b1;
          busy_q         <= 1'b0;
          state_q        <= IDLE;
        end
      endcase
    end
  end

  assign bus.start_ready  = start_ready_q;
  assign bus.result_valid = result_valid_q;
  assign bus.quotient     = quotient_q;
  assign bus.remainder    = remainder_q;
  assign bus.div_by_zero  = dbz_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed and randomized back-to-back checks of shift_sub_divider at N=8.
module tb_shift_sub_divider;

  localparam int N = 8;
  localparam int PERIOD = 10;

  logic clk;
  logic rst;

  shift_sub_divider_if #(.N(N)) bus ();

  shift_sub_divider #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #(PERIOD / 2) clk = ~clk;

  int  n_checks = 0;
  int  n_fail   = 0;
  time t_prev   = 0;
  bit  have_prev = 1'b0;
  bit  prev_dz   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Runs one operation starting from IDLE at a negedge; returns at the negedge after the result handshake.
  task automatic op(input logic [7:0] a, input logic [7:0] b, input int bp, input bit hold_sv);
    logic [7:0] eq, er;
    logic       edz;
    int         elat, lat;
    time        t_acc;
    if (b == 8'd0) begin
      eq = 8'hFF; er = a; edz = 1'b1; elat = 0;
    end else begin
      eq = a / b; er = a % b; edz = 1'b0; elat = N;
    end
    check("idle_ready", bus.start_ready, 1);
    bus.dividend     = a;
    bus.divisor      = b;
    bus.start_valid  = 1'b1;
    bus.result_ready = (bp == 0);
    @(posedge clk);
    t_acc = $time;
    if (have_prev)
      check("accept_spacing", 32'((t_acc - t_prev) / PERIOD), prev_dz ? 2 : N + 2);
    t_prev    = t_acc;
    prev_dz   = (b == 8'd0);
    have_prev = 1'b1;
    @(negedge clk);
    bus.dividend = 8'($urandom);
    bus.divisor  = 8'($urandom);
    if (!hold_sv) bus.start_valid = 1'b0;
    lat = 0;
    while (!bus.result_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, elat);
    check("quotient", bus.quotient, eq);
    check("remainder", bus.remainder, er);
    check("div_by_zero", bus.div_by_zero, edz);
    check("busy_done", bus.busy, 1);
    check("ready_done", bus.start_ready, 0);
    for (int k = 0; k < bp; k++) begin
      bus.start_valid = k[0];
      bus.dividend    = 8'($urandom);
      bus.divisor     = 8'($urandom);
      @(negedge clk);
      check("bp_valid", bus.result_valid, 1);
      check("bp_quotient", bus.quotient, eq);
      check("bp_remainder", bus.remainder, er);
      check("bp_dbz", bus.div_by_zero, edz);
      check("bp_ready", bus.start_ready, 0);
    end
    if (!hold_sv) bus.start_valid = 1'b0;
    bus.result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_valid", bus.result_valid, 0);
    check("post_ready", bus.start_ready, 1);
    check("post_busy", bus.busy, 0);
  endtask

  initial begin
    logic [7:0] ra, rb;
    rst              = 1'b1;
    bus.start_valid  = 1'b0;
    bus.dividend     = '0;
    bus.divisor      = '0;
    bus.result_ready = 1'b0;
    #1;
    check("rst_ready", bus.start_ready, 1);
    check("rst_valid", bus.result_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_quotient", bus.quotient, 0);
    check("rst_remainder", bus.remainder, 0);
    check("rst_dbz", bus.div_by_zero, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    op(8'd100, 8'd7, 0, 1'b0);
    op(8'd255, 8'd1, 0, 1'b0);
    op(8'd3, 8'd200, 0, 1'b0);
    op(8'd0, 8'd9, 0, 1'b0);
    op(8'd255, 8'd255, 0, 1'b0);
    op(8'd5, 8'd0, 0, 1'b0);

    // Backpressure with ignored start pulses, then confirm nothing was accepted.
    op(8'd77, 8'd6, 5, 1'b0);
    @(negedge clk);
    check("no_stray_accept", bus.busy, 0);

    // Reset during the fourth CALC cycle.
    bus.dividend    = 8'd50;
    bus.divisor     = 8'd3;
    bus.start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_calc_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("abort_ready", bus.start_ready, 1);
    check("abort_valid", bus.result_valid, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_quotient", bus.quotient, 0);
    check("abort_remainder", bus.remainder, 0);
    check("abort_dbz", bus.div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    have_prev = 1'b0;
    op(8'd200, 8'd13, 0, 1'b0);

    // Back-to-back random operations, start_valid and result_ready held high.
    have_prev = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      op(ra, rb, 0, 1'b1);
    end
    bus.start_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
